// File: rtl/config_sr_sequencer.sv
// Drives the front-end static/dynamic configuration shift register over SCLK/SEL/SDI/SDO.
// Shifts the latched word MSB-first, can re-shift it to verify, then pulses SEL to latch it.
module config_sr_sequencer #(
    parameter int SIZESRSTAT = 88,
    parameter int SIZESRDYN  = 16,
    parameter int CLKDIV     = 4,
    parameter int LATCHCYC   = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  TGT_DYN,
    input  logic                  VERIFY,
    input  logic [SIZESRSTAT-1:0] STAT_WORD,
    input  logic [SIZESRDYN-1:0]  DYN_WORD,
    output logic                  SCLK,
    output logic                  SEL,
    output logic                  SDI,
    input  logic                  SDO,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR,
    output logic [SIZESRSTAT-1:0] RDBK
);

    localparam int CNTMAX = (CLKDIV > LATCHCYC) ? CLKDIV : LATCHCYC;
    localparam int CW     = $clog2(CNTMAX + 1);
    localparam int BW     = $clog2(SIZESRSTAT + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        LATCH    = 3'd4
    } state_t;

    state_t                  state_r;
    logic [CW-1:0]           cnt_r;
    logic [BW-1:0]           bits_r;
    logic [SIZESRSTAT-1:0]   shift_r;
    logic                    tgt_r;
    logic                    verify_r;
    logic                    pass2_r;

    logic [SIZESRSTAT-1:0]   rot_s;
    logic                    msb_s;
    logic                    next_msb_s;
    logic [SIZESRSTAT-1:0]   start_word_s;
    logic                    start_msb_s;
    logic                    div_end_s;
    logic                    latch_end_s;
    logic [BW-1:0]           nbits_s;

    // Rotation of the active N-bit window and the bit currently on SDI
    always_comb begin
        rot_s = shift_r;
        if (tgt_r) begin
            rot_s[SIZESRDYN-1:0] = {shift_r[SIZESRDYN-2:0], shift_r[SIZESRDYN-1]};
            msb_s                = shift_r[SIZESRDYN-1];
            next_msb_s           = rot_s[SIZESRDYN-1];
            nbits_s              = BW'(SIZESRDYN);
        end else begin
            rot_s      = {shift_r[SIZESRSTAT-2:0], shift_r[SIZESRSTAT-1]};
            msb_s      = shift_r[SIZESRSTAT-1];
            next_msb_s = rot_s[SIZESRSTAT-1];
            nbits_s    = BW'(SIZESRSTAT);
        end
    end

    // Payload selection at request time
    always_comb begin
        if (TGT_DYN) begin
            start_word_s = {{(SIZESRSTAT-SIZESRDYN){1'b0}}, DYN_WORD};
            start_msb_s  = DYN_WORD[SIZESRDYN-1];
        end else begin
            start_word_s = STAT_WORD;
            start_msb_s  = STAT_WORD[SIZESRSTAT-1];
        end
    end

    assign div_end_s   = (cnt_r == CW'(CLKDIV - 1));
    assign latch_end_s = (cnt_r == CW'(LATCHCYC - 1));

    // Sequencer FSM with registered pin outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            bits_r   <= '0;
            shift_r  <= '0;
            tgt_r    <= 1'b0;
            verify_r <= 1'b0;
            pass2_r  <= 1'b0;
            SCLK     <= 1'b0;
            SEL      <= 1'b0;
            SDI      <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            RDBK     <= '0;
        end else begin
            DONE <= 1'b0;
            case (state_r)
                IDLE: begin
                    SCLK <= 1'b0;
                    // DONE still high means this is the completion cycle: drop START
                    if (START && !DONE) begin
                        shift_r  <= start_word_s;
                        tgt_r    <= TGT_DYN;
                        verify_r <= VERIFY;
                        pass2_r  <= 1'b0;
                        bits_r   <= TGT_DYN ? BW'(SIZESRDYN) : BW'(SIZESRSTAT);
                        cnt_r    <= '0;
                        ERR      <= 1'b0;
                        RDBK     <= '0;
                        BUSY     <= 1'b1;
                        SEL      <= TGT_DYN;
                        SDI      <= start_msb_s;
                        state_r  <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_end_s) begin
                        cnt_r   <= '0;
                        state_r <= SHIFT_LO;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                SHIFT_LO: begin
                    if (div_end_s) begin
                        cnt_r <= '0;
                        if (!pass2_r) begin
                            RDBK <= {RDBK[SIZESRSTAT-2:0], SDO};
                        end else if (SDO != msb_s) begin
                            ERR <= 1'b1;
                        end
                        SCLK    <= 1'b1;
                        state_r <= SHIFT_HI;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                SHIFT_HI: begin
                    if (div_end_s) begin
                        cnt_r   <= '0;
                        SCLK    <= 1'b0;
                        shift_r <= rot_s;
                        SDI     <= next_msb_s;
                        if (bits_r == BW'(1)) begin
                            if (pass2_r || !verify_r) begin
                                SEL     <= ~tgt_r;
                                state_r <= LATCH;
                            end else begin
                                pass2_r <= 1'b1;
                                bits_r  <= nbits_s;
                                state_r <= SHIFT_LO;
                            end
                        end else begin
                            bits_r  <= bits_r - BW'(1);
                            state_r <= SHIFT_LO;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                LATCH: begin
                    if (latch_end_s) begin
                        cnt_r   <= '0;
                        DONE    <= 1'b1;
                        BUSY    <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_sr_sequencer.sv
// Directed bench: a CLKDIV=1 instance with a behavioural config-register model,
// plus a CLKDIV=3 instance watched for SCLK phase lengths and pin-change ordering.
module tb_config_sr_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    // Instance 1 (CLKDIV=1)
    logic        start1, tgt1, ver1;
    logic [87:0] sw1;
    logic [15:0] dw1;
    logic        sclk1, sel1, sdi1, sdo1, busy1, done1, err1;
    logic [87:0] rdbk1;

    config_sr_sequencer #(.SIZESRSTAT(88), .SIZESRDYN(16), .CLKDIV(1), .LATCHCYC(8)) dut1 (
        .CLK(clk), .RST(rst), .START(start1), .TGT_DYN(tgt1), .VERIFY(ver1),
        .STAT_WORD(sw1), .DYN_WORD(dw1), .SCLK(sclk1), .SEL(sel1), .SDI(sdi1),
        .SDO(sdo1), .BUSY(busy1), .DONE(done1), .ERR(err1), .RDBK(rdbk1)
    );

    // Instance 3 (CLKDIV=3)
    logic        start3, tgt3, ver3;
    logic [87:0] sw3;
    logic [15:0] dw3;
    logic        sclk3, sel3, sdi3, busy3, done3, err3;
    logic        sdo3 = 1'b0;
    logic [87:0] rdbk3;

    config_sr_sequencer #(.SIZESRSTAT(88), .SIZESRDYN(16), .CLKDIV(3), .LATCHCYC(8)) dut3 (
        .CLK(clk), .RST(rst), .START(start3), .TGT_DYN(tgt3), .VERIFY(ver3),
        .STAT_WORD(sw3), .DYN_WORD(dw3), .SCLK(sclk3), .SEL(sel3), .SDI(sdi3),
        .SDO(sdo3), .BUSY(busy3), .DONE(done3), .ERR(err3), .RDBK(rdbk3)
    );

    // Config register model: shifts on SCLK rise, shadow latches follow SEL edges
    logic [87:0] stat_sr = 88'd0;
    logic [15:0] dyn_sr  = 16'd0;
    logic [87:0] statcnf = 88'd0;
    logic [15:0] dyncnf  = 16'd0;
    logic [87:0] pre_stat = 88'd0;
    logic [15:0] pre_dyn  = 16'd0;
    logic        pre_en   = 1'b0;
    logic        sdo_stuck = 1'b0;
    logic        sclk_d = 1'b0;
    logic        sel_d  = 1'b0;
    int          rises = 0;
    int          sel_rises = 0;

    assign sdo1 = sdo_stuck ? 1'b0 : (sel1 ? dyn_sr[15] : stat_sr[87]);

    always @(posedge clk) begin
        sclk_d <= sclk1;
        sel_d  <= sel1;
        if (pre_en) begin
            stat_sr <= pre_stat;
            dyn_sr  <= pre_dyn;
        end else if (sclk1 === 1'b1 && sclk_d === 1'b0) begin
            rises <= rises + 1;
            if (sel1) begin
                dyn_sr    <= {dyn_sr[14:0], sdi1};
                sel_rises <= sel_rises + 1;
            end else begin
                stat_sr <= {stat_sr[86:0], sdi1};
            end
        end
        if (sel1 === 1'b1 && sel_d === 1'b0) statcnf <= stat_sr;
        if (sel1 === 1'b0 && sel_d === 1'b1) dyncnf  <= dyn_sr;
    end

    // Phase/ordering monitor on instance 3
    logic p_sclk = 1'b0, p_sdi = 1'b0, p_sel = 1'b0, seen_hi = 1'b0;
    int   run = 1, hi_runs = 0, lo_runs = 0, phase_bad = 0, edge_bad = 0;

    always @(negedge clk) begin
        p_sclk <= sclk3;
        p_sdi  <= sdi3;
        p_sel  <= sel3;
        if (sclk3 === 1'b1 && (sdi3 !== p_sdi || sel3 !== p_sel)) edge_bad <= edge_bad + 1;
        if (sclk3 === p_sclk) begin
            run <= run + 1;
        end else begin
            run <= 1;
            if (p_sclk) begin
                hi_runs <= hi_runs + 1;
                seen_hi <= 1'b1;
                if (run != 3) phase_bad <= phase_bad + 1;
            end else if (seen_hi) begin
                lo_runs <= lo_runs + 1;
                if (run != 3) phase_bad <= phase_bad + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [87:0] obs, input logic [87:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One request on instance 1, checking BUSY and START-to-DONE latency
    task automatic run1(input string tag, input logic tgt, input logic ver,
                        input logic [87:0] sw, input logic [15:0] dw, input int exp_lat);
        int cyc;
        @(negedge clk);
        tgt1 = tgt; ver1 = ver; sw1 = sw; dw1 = dw; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check({tag, "_busy_on"}, 88'(busy1), 88'd1);
        cyc = 1;
        while (done1 !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 88'(cyc), 88'(exp_lat));
        check({tag, "_busy_off"}, 88'(busy1), 88'd0);
    endtask

    int r0, s0, cyc;
    logic busy_seen;

    initial begin
        rst = 1'b1;
        start1 = 1'b0; tgt1 = 1'b0; ver1 = 1'b0; sw1 = 88'd0; dw1 = 16'd0;
        start3 = 1'b0; tgt3 = 1'b0; ver3 = 1'b0; sw3 = 88'd0; dw3 = 16'd0;
        repeat (3) @(negedge clk);
        check("reset_pins", 88'({sclk1, sel1, sdi1, busy1, done1, err1}), 88'd0);
        check("reset_rdbk", rdbk1, 88'd0);
        rst = 1'b0;

        pre_stat = 88'h0123456789ABCDEF012345;
        pre_dyn  = 16'h4000;
        pre_en   = 1'b1;
        @(negedge clk);
        pre_en   = 1'b0;

        // 1) static load, no verify
        r0 = rises; s0 = sel_rises;
        run1("t1", 1'b0, 1'b0, {11{8'hA5}}, 16'h0000, 186);
        check("t1_rises", 88'(rises - r0), 88'd88);
        check("t1_sel_during_shift", 88'(sel_rises - s0), 88'd0);
        check("t1_statcnf", statcnf, {11{8'hA5}});
        check("t1_rdbk", rdbk1, 88'h0123456789ABCDEF012345);
        check("t1_err", 88'(err1), 88'd0);

        // 2) dynamic load with verify
        r0 = rises; s0 = sel_rises;
        run1("t2", 1'b1, 1'b1, 88'd0, 16'h4C3A, 74);
        check("t2_rises", 88'(rises - r0), 88'd32);
        check("t2_sel_during_shift", 88'(sel_rises - s0), 88'd32);
        check("t2_rdbk", rdbk1, 88'h4000);
        check("t2_err", 88'(err1), 88'd0);
        check("t2_dyncnf", 88'(dyncnf), 88'h4C3A);
        check("t2_sel_end", 88'(sel1), 88'd0);

        // 3) verify failure with SDO stuck low, then ERR clears on next START
        sdo_stuck = 1'b1;
        run1("t3", 1'b1, 1'b1, 88'd0, 16'h0001, 74);
        check("t3_err_set", 88'(err1), 88'd1);
        check("t3_rdbk", rdbk1, 88'd0);
        sdo_stuck = 1'b0;
        repeat (3) @(negedge clk);
        check("t3_err_sticky", 88'(err1), 88'd1);
        tgt1 = 1'b1; ver1 = 1'b0; dw1 = 16'h1234; start1 = 1'b1;
        check("t3_err_before_start", 88'(err1), 88'd1);
        @(negedge clk);
        start1 = 1'b0;
        check("t3_err_cleared", 88'(err1), 88'd0);
        cyc = 1;
        while (done1 !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("t3b_latency", 88'(cyc), 88'd42);
        check("t3b_dyncnf", 88'(dyncnf), 88'h1234);

        // 4) START during BUSY and on the DONE cycle is dropped
        r0 = rises;
        @(negedge clk);
        tgt1 = 1'b1; ver1 = 1'b0; dw1 = 16'hBEEF; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cyc = 1;
        while (done1 !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 10) begin
                dw1 = 16'h0F0F; start1 = 1'b1;
            end else begin
                start1 = 1'b0;
            end
        end
        check("t4_latency", 88'(cyc), 88'd42);
        dw1 = 16'h5555; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        busy_seen = 1'b0;
        repeat (6) begin
            if (busy1 !== 1'b0) busy_seen = 1'b1;
            @(negedge clk);
        end
        check("t4_no_restart", 88'(busy_seen), 88'd0);
        check("t4_rises", 88'(rises - r0), 88'd16);
        check("t4_dyncnf", 88'(dyncnf), 88'hBEEF);

        // 5) reset in the middle of a SHIFT_HI phase, then a clean reload
        @(negedge clk);
        tgt1 = 1'b0; ver1 = 1'b0; sw1 = {11{8'h3C}}; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cyc = 1;
        while (!(cyc >= 30 && sclk1 === 1'b1) && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("t5_in_shift_hi", 88'({sclk1, busy1}), 88'b11);
        rst = 1'b1;
        @(negedge clk);
        check("t5_reset_pins", 88'({sclk1, sel1, sdi1, busy1, done1, err1}), 88'd0);
        check("t5_reset_rdbk", rdbk1, 88'd0);
        rst = 1'b0;
        run1("t5", 1'b0, 1'b0, 88'hFEDCBA9876543210FEDCBA, 16'h0000, 186);
        check("t5_statcnf", statcnf, 88'hFEDCBA9876543210FEDCBA);

        // 6) CLKDIV=3 instance: phase lengths and pin ordering
        @(negedge clk);
        tgt3 = 1'b1; ver3 = 1'b0; dw3 = 16'hB2C5; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        cyc = 1;
        while (done3 !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("t6_latency", 88'(cyc), 88'd108);
        check("t6_hi_runs", 88'(hi_runs), 88'd16);
        check("t6_lo_runs", 88'(lo_runs), 88'd15);
        check("t6_phase_len", 88'(phase_bad), 88'd0);
        check("t6_pin_order", 88'(edge_bad), 88'd0);
        check("t6_sel_end", 88'(sel3), 88'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
